shift_reg_sequencer: RTL

Controller that sequences the universal shift register datapath (hold / shift-toward-MSB / parallel load / shift-toward-LSB) to perform one complete serial transfer per request. It accepts a word via a valid/ready handshake and parallel-loads it into the register. It then issues a programmable number of shift strobes at a programmable rate, feeding the external serial input into the register. Finally it captures the register contents and reports completion. It sits between a request source (host logic or pins) and the register's CTRL/ENABLE/D/S_IN inputs.

---
 rtl/shift_reg_sequencer_if.sv | 14 +
 rtl/shift_reg_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/shift_reg_sequencer_if.sv
// rtl/shift_reg_sequencer_if.sv - request handshake bundle for the shift register sequencer
interface shift_reg_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic             req_dir;
  logic [LEN_W-1:0] req_len;

  modport master (output req_valid, req_data, req_dir, req_len, input req_ready);
  modport slave  (input req_valid, req_data, req_dir, req_len, output req_ready);
endinterface

// File: rtl/shift_reg_sequencer.sv
// rtl/shift_reg_sequencer.sv - load / shift / capture sequencer for a universal shift register
module shift_reg_sequencer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int DIV   = 1
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  shift_reg_sequencer_if.slave req,
  input  logic                 abort,
  input  logic                 ser_in,
  input  logic [WIDTH-1:0]     reg_q,
  output logic [1:0]           reg_ctrl,
  output logic                 reg_en,
  output logic [WIDTH-1:0]     reg_d,
  output logic                 reg_sin,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     rsp_data
);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPTURE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [LEN_W-1:0] eff_len;
  logic             strobe;

  always_comb begin
    eff_len = req.req_len;
    if (req.req_len == '0 || req.req_len > LEN_W'(WIDTH))
      eff_len = LEN_W'(WIDTH);
  end

  // An abort suppresses the strobe in the same cycle it is sampled.
  assign strobe = (state == SHIFT) && (div_q == DIV_LAST) && !abort;

  always_comb begin
    reg_en   = 1'b0;
    reg_ctrl = 2'b00;
    reg_sin  = 1'b0;
    if (state == LOAD && !abort) begin
      reg_en   = 1'b1;
      reg_ctrl = 2'b10;
    end else if (strobe) begin
      reg_en   = 1'b1;
      reg_ctrl = dir_q ? 2'b11 : 2'b01;
      reg_sin  = ser_in;
    end
  end

  assign reg_d         = data_q;
  assign req.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= IDLE;
      data_q   <= '0;
      dir_q    <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      rsp_data <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req.req_valid) begin
            data_q <= req.req_data;
            dir_q  <= req.req_dir;
            len_q  <= eff_len;
            state  <= LOAD;
          end
        end
        LOAD: begin
          cnt_q <= '0;
          div_q <= '0;
          state <= abort ? IDLE : SHIFT;
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
          end else if (strobe) begin
            div_q <= '0;
            cnt_q <= cnt_q + LEN_W'(1);
            if (cnt_q + LEN_W'(1) == len_q)
              state <= CAPTURE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        CAPTURE: begin
          rsp_data <= reg_q;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
